// File: rtl/uart_tx_wrapper_pkg.sv
// Shared types and constants for the UART word transmitter.
package uart_tx_wrapper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_type;

    localparam int UART_BITS_PER_FRAME = 10;
    localparam int UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/tx_word_fifo.sv
// Word FIFO between the push handshake and the serializer.
module tx_word_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_wrapper.sv
// 8N1 UART transmitter sending buffered 32-bit words, LSB byte first.
module uart_tx_wrapper
    import uart_tx_wrapper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        io_tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(UART_BYTES_PER_WORD - 1);

    uart_tx_state_type r_state;
    uart_tx_state_type w_state_nxt;
    logic [BW-1:0]     r_baud;
    logic [BW-1:0]     w_baud_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [1:0]        r_byte_idx;
    logic [1:0]        w_byte_nxt;
    logic [31:0]       r_shift;
    logic [31:0]       w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic [15:0]       r_words_sent;
    logic [15:0]       w_words_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_bit_end;
    logic              w_last_stop;
    logic [31:0]       w_fifo_dout;
    logic [CW-1:0]     w_count;

    tx_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (data_in),
        .dout    (w_fifo_dout),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign data_ready  = !w_full;
    assign w_push      = data_valid && data_ready;
    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_stop = (r_state == STOP) && w_bit_end
                         && (r_byte_idx == BYTE_LAST);
    assign w_pop       = !w_empty
                         && ((r_state == IDLE) || w_last_stop);

    assign io_tx      = r_tx;
    assign busy       = (w_count != '0) || (r_state != IDLE);
    assign words_sent = r_words_sent;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_words_nxt = r_words_sent;

        if (r_state != IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_nxt = START;
                    w_shift_nxt = w_fifo_dout;
                    w_byte_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                // The word shifts right as a whole, so the next byte
                // lands in [7:0] once all eight bits are out.
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_byte_idx != BYTE_LAST) begin
                        w_state_nxt = START;
                        w_byte_nxt  = r_byte_idx + 1'b1;
                        w_bit_nxt   = '0;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_words_nxt = r_words_sent + 1'b1;
                        if (w_pop) begin
                            w_state_nxt = START;
                            w_shift_nxt = w_fifo_dout;
                            w_byte_nxt  = '0;
                            w_bit_nxt   = '0;
                            w_tx_nxt    = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_words_sent <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_byte_idx   <= w_byte_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_words_sent <= w_words_nxt;
        end
    end

endmodule
